// File: rtl/adc_pkg.sv
// adc_pkg: state encoding, acquisition modes and default widths
// shared by the ADC sample sequencer and its clock divider.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    localparam int DIV_W_DEF = 14;
    localparam int BL_W_DEF  = 16;

endpackage

// File: rtl/adc_clk_div.sv
// adc_clk_div: half-period counter and registered toggle flop that
// produce adc_clk plus look-ahead rise/fall strobes for the sequencer.
module adc_clk_div
    import adc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] half,
    input  logic             no_rise,
    output logic             adc_clk,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    logic [DIV_W-1:0] cnt;
    logic             tick;

    assign tick       = en && (cnt == half);
    assign rise_pulse = tick && !adc_clk && !no_rise;
    // While draining, a low-phase toggle point also ends the acquisition.
    assign fall_pulse = tick && (adc_clk || no_rise);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
        end else if (tick) begin
            cnt     <= '0;
            adc_clk <= rise_pulse;
        end else begin
            cnt     <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: acquisition FSM, shadow registers, channel
// rotator and sample counter around the adc_clk divider.
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int BL_W  = BL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [DIV_W-1:0] bn,
    input  logic             mode,
    input  logic [BL_W-1:0]  burst_len,
    input  logic [NCH-1:0]   ch_en,
    input  logic             start,
    input  logic             stop,
    output logic             adc_clk,
    output logic             trigger,
    output logic [CH_W-1:0]  ch_sel,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] bn_q, bn_p;
    logic             mode_q, mode_p;
    logic [BL_W-1:0]  burst_len_q, burst_len_p;
    logic [NCH-1:0]   ch_en_q, ch_en_p;
    logic             pend_vld;
    logic [BL_W-1:0]  smp_cnt, smp_inc, bl_eff;
    logic [CH_W-1:0]  first_ch, nxt_ch;
    logic             div_en, no_rise, rise_pulse, fall_pulse;
    logic             burst_last, go, fin;

    adc_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (div_en),
        .half       (bn_q),
        .no_rise    (no_rise),
        .adc_clk    (adc_clk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign smp_inc    = (&smp_cnt) ? smp_cnt : smp_cnt + BL_W'(1);
    assign bl_eff     = (burst_len_q == '0) ? BL_W'(1) : burst_len_q;
    assign burst_last = (mode_q == MODE_BURST) && rise_pulse
                        && (smp_inc >= bl_eff);

    // Descending scans so the nearest enabled channel wins.
    always_comb begin
        first_ch = '0;
        nxt_ch   = ch_sel;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_en_q[i]) first_ch = CH_W'(i);
        end
        for (int i = NCH - 1; i >= 1; i--) begin
            if (ch_en_q[(int'(ch_sel) + i) % NCH])
                nxt_ch = CH_W'((int'(ch_sel) + i) % NCH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (start && !stop && (ch_en_q != '0))
                    state_nxt = ST_RUN;
            ST_RUN:
                if (stop || burst_last) state_nxt = ST_STOPPING;
            ST_STOPPING:
                if (fall_pulse) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        div_en  = (state != ST_IDLE);
        no_rise = (state == ST_STOPPING);
        go      = (state == ST_IDLE) && (state_nxt == ST_RUN);
        fin     = (state == ST_STOPPING) && fall_pulse;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trigger <= 1'b0;
            done    <= 1'b0;
            ch_sel  <= '0;
            smp_cnt <= '0;
        end else begin
            trigger <= rise_pulse;
            done    <= fin;
            if (go) begin
                ch_sel  <= first_ch;
                smp_cnt <= '0;
            end else begin
                if ((state == ST_RUN) && fall_pulse) ch_sel <= nxt_ch;
                if (rise_pulse) smp_cnt <= smp_inc;
            end
        end
    end

    // Writes during acquisition wait for a falling toggle so a
    // half-period is never cut short or stretched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bn_q        <= '0;
            mode_q      <= MODE_CONT;
            burst_len_q <= BL_W'(1);
            ch_en_q     <= NCH'(1);
            pend_vld    <= 1'b0;
            bn_p        <= '0;
            mode_p      <= MODE_CONT;
            burst_len_p <= '0;
            ch_en_p     <= '0;
        end else if (state == ST_IDLE) begin
            pend_vld <= 1'b0;
            if (we) begin
                bn_q        <= bn;
                mode_q      <= mode;
                burst_len_q <= burst_len;
                ch_en_q     <= ch_en;
            end else if (pend_vld) begin
                bn_q        <= bn_p;
                mode_q      <= mode_p;
                burst_len_q <= burst_len_p;
                ch_en_q     <= ch_en_p;
            end
        end else begin
            if (fall_pulse && pend_vld) begin
                bn_q        <= bn_p;
                mode_q      <= mode_p;
                burst_len_q <= burst_len_p;
                ch_en_q     <= ch_en_p;
                pend_vld    <= 1'b0;
            end
            if (we) begin
                bn_p        <= bn;
                mode_p      <= mode;
                burst_len_p <= burst_len;
                ch_en_p     <= ch_en;
                pend_vld    <= 1'b1;
            end
        end
    end

endmodule
